hilo_write_unit: RTL

EX-stage producer of all HI/LO writes: multiply, iterative divide, MTHI and MTLO. It generates the write enable and data that travel down the pipeline to the HI/LO register, the same write enable and data the EX-stage HI/LO read forwarding consumes from MEM and WB. Divides take multiple cycles, and the unit holds the pipeline with a stall request until the result is ready.

---
 rtl/hilo_write_unit_pkg.sv | 26 ++
 rtl/hilo_write_unit_if.sv | 27 ++
 rtl/hilo_div_iter.sv | 60 ++++++
 rtl/hilo_write_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/hilo_write_unit_pkg.sv
// Shared encodings for the HI/LO write unit: operation codes, FSM states,
// bus width and write-enable constants.
package hilo_write_unit_pkg;

    localparam int DATA_BUS = 32;

    localparam logic [2:0] HILO_OP_NOP   = 3'd0;
    localparam logic [2:0] HILO_OP_MULT  = 3'd1;
    localparam logic [2:0] HILO_OP_MULTU = 3'd2;
    localparam logic [2:0] HILO_OP_DIV   = 3'd3;
    localparam logic [2:0] HILO_OP_DIVU  = 3'd4;
    localparam logic [2:0] HILO_OP_MTHI  = 3'd5;
    localparam logic [2:0] HILO_OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [DATA_BUS-1:0] WORD_ZERO = '0;
    localparam logic [DATA_BUS-1:0] WORD_ONES = '1;
    localparam logic [DATA_BUS-1:0] WORD_MIN  = {1'b1, {(DATA_BUS-1){1'b0}}};

endpackage

// File: rtl/hilo_write_unit_if.sv
// EX-stage bundle between the pipeline (master) and the HI/LO write unit (slave).
interface hilo_write_unit_if;
    import hilo_write_unit_pkg::*;

    logic                flush;
    logic                op_valid;
    logic [2:0]          op;
    logic [DATA_BUS-1:0] operand_a;
    logic [DATA_BUS-1:0] operand_b;
    logic [DATA_BUS-1:0] hi_val_in;
    logic [DATA_BUS-1:0] lo_val_in;
    logic                stall_request;
    logic                write_hilo_en;
    logic [DATA_BUS-1:0] write_hi_data;
    logic [DATA_BUS-1:0] write_lo_data;

    modport master (
        output flush, op_valid, op, operand_a, operand_b, hi_val_in, lo_val_in,
        input  stall_request, write_hilo_en, write_hi_data, write_lo_data
    );

    modport slave (
        input  flush, op_valid, op, operand_a, operand_b, hi_val_in, lo_val_in,
        output stall_request, write_hilo_en, write_hi_data, write_lo_data
    );

endinterface

// File: rtl/hilo_div_iter.sv
// Unsigned 32-step restoring divider; one quotient bit per cycle after start.
// done is high during the cycle that performs the final step.
module hilo_div_iter
    import hilo_write_unit_pkg::*;
(
    input  logic                clk,
    input  logic                cancel,
    input  logic                start,
    input  logic [DATA_BUS-1:0] dividend,
    input  logic [DATA_BUS-1:0] divisor,
    output logic                done,
    output logic [DATA_BUS-1:0] quotient,
    output logic [DATA_BUS-1:0] remainder
);

    logic                busy;
    logic [4:0]          cnt;
    logic [DATA_BUS-1:0] rem;
    logic [DATA_BUS-1:0] quo;
    logic [DATA_BUS-1:0] dvs;
    logic [DATA_BUS:0]   rem_shift;
    logic [DATA_BUS:0]   diff;

    // Shift in the next dividend bit and try subtracting the divisor
    assign rem_shift = {rem, quo[DATA_BUS-1]};
    assign diff      = rem_shift - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (cancel) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            rem  <= '0;
            quo  <= dividend;
            dvs  <= divisor;
        end else if (busy) begin
            if (!diff[DATA_BUS]) begin
                rem <= diff[DATA_BUS-1:0];
                quo <= {quo[DATA_BUS-2:0], 1'b1};
            end else begin
                rem <= rem_shift[DATA_BUS-1:0];
                quo <= {quo[DATA_BUS-2:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                busy <= 1'b0;
            end
        end
    end

    assign done      = busy && (cnt == 5'd31);
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/hilo_write_unit.sv
// EX-stage HI/LO producer: combinational multiply and MTHI/MTLO, iterative
// divide with pipeline stall, and the single write port toward MEM/WB.
module hilo_write_unit
    import hilo_write_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    hilo_write_unit_if.slave bus
);

    function automatic logic [DATA_BUS-1:0] apply_sign(input logic neg,
                                                       input logic [DATA_BUS-1:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                neg_q;
    logic                neg_r;
    logic                special;
    logic [DATA_BUS-1:0] sp_hi;
    logic [DATA_BUS-1:0] sp_lo;

    logic                accept;
    logic                is_div;
    logic                div_accept;
    logic                div_signed;
    logic                a_neg;
    logic                b_neg;
    logic                div_by_zero;
    logic                div_ovf;
    logic                special_now;
    logic                div_start;
    logic                div_done;
    logic [DATA_BUS-1:0] mag_a;
    logic [DATA_BUS-1:0] mag_b;
    logic [DATA_BUS-1:0] div_quo;
    logic [DATA_BUS-1:0] div_rem;

    logic signed [2*DATA_BUS-1:0] mul_a;
    logic signed [2*DATA_BUS-1:0] mul_b;
    logic signed [2*DATA_BUS-1:0] product;

    assign accept     = bus.op_valid && !bus.flush && (state == ST_IDLE);
    assign is_div     = (bus.op == HILO_OP_DIV) || (bus.op == HILO_OP_DIVU);
    assign div_accept = accept && is_div;
    assign div_signed = (bus.op == HILO_OP_DIV);

    assign a_neg = div_signed && bus.operand_a[DATA_BUS-1];
    assign b_neg = div_signed && bus.operand_b[DATA_BUS-1];
    assign mag_a = apply_sign(a_neg, bus.operand_a);
    assign mag_b = apply_sign(b_neg, bus.operand_b);

    // Results the restoring loop cannot produce are resolved up front
    assign div_by_zero = (bus.operand_b == WORD_ZERO);
    assign div_ovf     = div_signed && (bus.operand_a == WORD_MIN) && (bus.operand_b == WORD_ONES);
    assign special_now = div_by_zero || div_ovf;
    assign div_start   = div_accept && !special_now;

    // Extending to 64 bits first lets one multiplier serve MULT and MULTU
    always_comb begin
        if (bus.op == HILO_OP_MULT) begin
            mul_a = {{DATA_BUS{bus.operand_a[DATA_BUS-1]}}, bus.operand_a};
            mul_b = {{DATA_BUS{bus.operand_b[DATA_BUS-1]}}, bus.operand_b};
        end else begin
            mul_a = {WORD_ZERO, bus.operand_a};
            mul_b = {WORD_ZERO, bus.operand_b};
        end
    end

    assign product = mul_a * mul_b;

    hilo_div_iter u_div (
        .clk       (clk),
        .cancel    (rst || bus.flush),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_next        = state;
        bus.stall_request = 1'b0;
        bus.write_hilo_en = WRITE_DISABLE;
        bus.write_hi_data = WORD_ZERO;
        bus.write_lo_data = WORD_ZERO;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        HILO_OP_MULT, HILO_OP_MULTU: begin
                            bus.write_hilo_en = WRITE_ENABLE;
                            bus.write_hi_data = product[2*DATA_BUS-1:DATA_BUS];
                            bus.write_lo_data = product[DATA_BUS-1:0];
                        end
                        HILO_OP_MTHI: begin
                            bus.write_hilo_en = WRITE_ENABLE;
                            bus.write_hi_data = bus.operand_a;
                            bus.write_lo_data = bus.lo_val_in;
                        end
                        HILO_OP_MTLO: begin
                            bus.write_hilo_en = WRITE_ENABLE;
                            bus.write_hi_data = bus.hi_val_in;
                            bus.write_lo_data = bus.operand_a;
                        end
                        HILO_OP_DIV, HILO_OP_DIVU: begin
                            bus.stall_request = 1'b1;
                            state_next        = special_now ? ST_DONE : ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                bus.stall_request = 1'b1;
                if (div_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.write_hilo_en = WRITE_ENABLE;
                bus.write_hi_data = special ? sp_hi : apply_sign(neg_r, div_rem);
                bus.write_lo_data = special ? sp_lo : apply_sign(neg_q, div_quo);
                state_next        = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_next        = ST_IDLE;
            bus.stall_request = 1'b0;
            bus.write_hilo_en = WRITE_DISABLE;
            bus.write_hi_data = WORD_ZERO;
            bus.write_lo_data = WORD_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
            sp_hi   <= '0;
            sp_lo   <= '0;
        end else begin
            state <= state_next;
            if (div_accept) begin
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                special <= special_now;
                sp_hi   <= div_by_zero ? bus.operand_a : WORD_ZERO;
                sp_lo   <= div_by_zero ? WORD_ONES : WORD_MIN;
            end
        end
    end

endmodule
